// File: rtl/program_loader.sv
// Byte-stream program loader: assembles framed host bytes into 32-bit words and writes them to instruction memory.
// Optional checksum byte after the image is enabled with `define LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [7:0] START_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]         word_idx;
  logic [CW-1:0]         target;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] word;
  logic                  hold;
  logic                  accept;
  logic                  last_word;

  assign accept    = rx_valid && rx_ready;
  assign last_word = (word_idx + CW'(1)) == target;
  assign mem_addr  = word_idx[ADDR_WIDTH-1:0];
  assign mem_wdata = word;
  assign cpu_hold  = hold;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       err_q;
  assign err = err_q;

  // Running sum covers data bytes only; a mismatch leaves the CPU held until the next start byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (state == IDLE && rx_data == START_BYTE) begin
        sum   <= '0;
        err_q <= 1'b0;
      end else if (state == DATA) begin
        sum <= sum + rx_data;
      end else if (state == CHECK && rx_data != sum) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (accept && rx_data == START_BYTE) next_state = COUNT;
      end
      COUNT: begin
        rx_ready = 1'b1;
        if (accept) next_state = DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        if (accept && byte_cnt == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        next_state = last_word ? CHECK : DATA;
`else
        next_state = last_word ? DONE : DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        if (accept) next_state = (rx_data == sum) ? DONE : IDLE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Word index advances after each write so the address seen during WRITE is the slot being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx <= '0;
      target   <= '0;
      byte_cnt <= '0;
      word     <= '0;
      hold     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && rx_data == START_BYTE) begin
            hold     <= 1'b1;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        COUNT: begin
          if (accept) target <= (rx_data == 8'd0) ? FULL_COUNT : CW'(rx_data);
        end
        DATA: begin
          if (accept) begin
            word     <= {word[DATA_WIDTH-9:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: word_idx <= word_idx + CW'(1);
        DONE:  hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; expected memory writes are queued as bytes are sent and
// checked by a monitor when mem_we pulses.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          gap_mode = 0;

  program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one byte from a negedge and returns at the negedge just after it was transferred.
  task automatic applyStimulus(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) checkOutput("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cnt, input bit good_sum);
    logic [7:0]  sum = 8'd0;
    logic [31:0] w;
    applyStimulus(8'hA5);
    checkOutput("hold_after_start", cpu_hold, 1'b1);
    checkOutput("err_cleared", err, 1'b0);
    applyStimulus(cnt);
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      exp_q.push_back('{addr: i[7:0], data: w});
      for (int b = 0; b < 4; b++) begin
        applyStimulus(w[31-8*b -: 8]);
        sum = sum + w[31-8*b -: 8];
        if (gap_mode && b == 1) begin
          rx_valid = 1'b0;
          repeat (3) @(negedge clk);
        end
      end
      checkOutput("we_latency", mem_we, 1'b1);
      checkOutput("ready_low_in_write", rx_ready, 1'b0);
    end
`ifdef LOADER_CHECKSUM_EN
    @(negedge clk);
    applyStimulus(good_sum ? sum : sum - 8'd1);
    rx_valid = 1'b0;
    checkOutput("done_after_check", done, good_sum);
    checkOutput("err_after_check", err, !good_sum);
    if (good_sum) exp_done++;
    @(negedge clk);
    checkOutput("hold_after_frame", cpu_hold, !good_sum);
`else
    rx_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_latency", done, 1'b1);
    exp_done++;
    @(negedge clk);
    checkOutput("hold_released", cpu_hold, 1'b0);
    checkOutput("done_single_pulse", done, 1'b0);
    if (good_sum) checkOutput("err_tied_low", err, 1'b0);
`endif
    checkOutput("pending_writes", exp_q.size(), 32'd0);
  endtask

  // Write/done monitor: every mem_we must match the next queued write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      checkOutput("hold_during_write", cpu_hold, 1'b1);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        checkOutput("write_data", mem_wdata, e.data);
      end
    end
    if (done) begin
      done_cnt++;
      checkOutput("hold_during_done", cpu_hold, 1'b1);
    end
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_hold", cpu_hold, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", rx_ready, 1'b1);

    $display("[TB] two-word frame");
    frame_words = '{32'h0040_0001, 32'h0800_0000};
    send_frame(8'h02, 1'b1);

    $display("[TB] garbage then one-word frame");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    rx_valid = 1'b0;
    checkOutput("garbage_no_hold", cpu_hold, 1'b0);
    frame_words = '{32'hDEAD_BEEF};
    send_frame(8'h01, 1'b1);

    $display("[TB] full 256-word frame");
    frame_words.delete();
    for (int k = 0; k < 256; k++) frame_words.push_back(k);
    send_frame(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("no_wrap_write", exp_q.size(), 32'd0);

    $display("[TB] back-to-back bytes across WRITE, then with gaps");
    frame_words = '{32'h1122_3344, 32'hA555_A5A5, 32'h99AA_BBCC};
    send_frame(8'h03, 1'b1);
    gap_mode = 1;
    send_frame(8'h03, 1'b1);
    gap_mode = 0;

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_mem_we", mem_we, 1'b0);
    checkOutput("midrst_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("midrst_wdata", mem_wdata, 32'd0);
    checkOutput("midrst_hold", cpu_hold, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_err", err, 1'b0);
    checkOutput("midrst_ready", rx_ready, 1'b1);
    frame_words = '{32'hAABB_CCDD};
    send_frame(8'h01, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum mismatch");
    frame_words = '{32'h0040_0001, 32'h0800_0000};
    send_frame(8'h02, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", err, 1'b1);
    checkOutput("hold_sticky", cpu_hold, 1'b1);
    frame_words = '{32'hCAFE_F00D};
    send_frame(8'h01, 1'b1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("done_count", done_cnt, exp_done);
    checkOutput("final_pending", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
